// File: rtl/wb_arbiter.sv
// Writeback arbiter: gathers results from several functional units into small
// per-unit FIFOs, picks one per cycle in round-robin order and registers it as
// the writeback strobe/index/data/tag. Speculative results are tracked per
// entry so that a flush squashes them before they reach the status table.
module wb_arbiter #(
  parameter int NUM_FU = 3,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 2,
  parameter int DEPTH  = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_FU-1:0]        fu_valid,
  output logic [NUM_FU-1:0]        fu_ready,
  input  logic [NUM_FU*5-1:0]      fu_rd,
  input  logic [NUM_FU*DATA_W-1:0] fu_data,
  input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
  input  logic [NUM_FU-1:0]        fu_spec,
  input  logic                     flush,
  input  logic                     resolve,
  output logic                     wb_write,
  output logic [4:0]               wb_sel,
  output logic [DATA_W-1:0]        wb_data,
  output logic [TAG_W-1:0]         wb_tag
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int GNT_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [GNT_W-1:0] LAST_FU  = GNT_W'(NUM_FU - 1);

  // Head-of-queue view of every FIFO, consumed by the arbiter.
  logic [NUM_FU-1:0] head_valid;
  logic [NUM_FU-1:0] head_spec;
  logic [4:0]        head_rd   [NUM_FU];
  logic [DATA_W-1:0] head_data [NUM_FU];
  logic [TAG_W-1:0]  head_tag  [NUM_FU];

  // Arbitration results.
  logic [NUM_FU-1:0] candidate;
  logic [NUM_FU-1:0] grant;
  logic              grant_any;
  logic [GNT_W-1:0]  grant_idx;
  logic [GNT_W-1:0]  last_grant_q, last_grant_d;

  // Output register.
  logic              out_valid_q, out_valid_d;
  logic              out_spec_q,  out_spec_d;
  logic [4:0]        out_rd_q,    out_rd_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [TAG_W-1:0]  out_tag_q,   out_tag_d;

  // Index of the k-th unit after base, wrapping modulo NUM_FU.
  function automatic logic [GNT_W-1:0] rr_index(input logic [GNT_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    return GNT_W'(s % NUM_FU);
  endfunction

  // ---------------------------------------------------------------------------
  // Per-unit result FIFOs. Entry 0 is always the head; the queue is kept
  // packed toward entry 0 so a flush can squeeze out speculative entries
  // anywhere in the queue while the survivors keep their order.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fifo
    logic [CNT_W-1:0]  count_q, count_d;
    logic [4:0]        rd_q   [DEPTH];
    logic [4:0]        rd_d   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [TAG_W-1:0]  tag_d  [DEPTH];
    logic              spec_q [DEPTH];
    logic              spec_d [DEPTH];
    logic [4:0]        in_rd;
    logic              enq_keep;

    assign in_rd = fu_rd[gi*5 +: 5];

    // Ready depends only on the registered count, never on this cycle's dequeue.
    assign fu_ready[gi] = (count_q != FULL_CNT);

    // A handshaken result is stored unless it targets x0 or is speculative
    // while a flush is in progress; in those cases it is accepted and dropped.
    assign enq_keep = fu_valid[gi] & fu_ready[gi] & (in_rd != 5'd0) &
                      ~(flush & fu_spec[gi]);

    assign head_valid[gi] = (count_q != '0);
    assign head_spec[gi]  = spec_q[0];
    assign head_rd[gi]    = rd_q[0];
    assign head_data[gi]  = data_q[0];
    assign head_tag[gi]   = tag_q[0];

    // A head that is about to be squashed must not win arbitration.
    assign candidate[gi] = head_valid[gi] & ~(flush & head_spec[gi]);
    assign grant[gi]     = grant_any & (grant_idx == GNT_W'(gi));

    // Next queue contents: drop the dequeued head and squashed entries,
    // compact the survivors, clear spec on resolve, then append the new result.
    always_comb begin : compact
      logic [CNT_W-1:0] wr;
      rd_d   = rd_q;
      data_d = data_q;
      tag_d  = tag_q;
      spec_d = spec_q;
      wr     = '0;
      for (int j = 0; j < DEPTH; j++) begin
        if ((CNT_W'(j) < count_q) && !(grant[gi] && (j == 0)) &&
            !(flush && spec_q[j])) begin
          rd_d[wr]   = rd_q[j];
          data_d[wr] = data_q[j];
          tag_d[wr]  = tag_q[j];
          spec_d[wr] = spec_q[j] & ~resolve;
          wr         = wr + 1'b1;
        end
      end
      if (enq_keep) begin
        rd_d[wr]   = in_rd;
        data_d[wr] = fu_data[gi*DATA_W +: DATA_W];
        tag_d[wr]  = fu_tag[gi*TAG_W +: TAG_W];
        spec_d[wr] = fu_spec[gi] & ~resolve;
        wr         = wr + 1'b1;
      end
      count_d = wr;
    end

    // Occupancy is the only FIFO state that needs a reset; it empties the queue.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        count_q <= '0;
      end else begin
        count_q <= count_d;
      end
    end

    // Entry payload storage; contents beyond count_q are never looked at.
    always_ff @(posedge CLK) begin
      rd_q   <= rd_d;
      data_q <= data_d;
      tag_q  <= tag_d;
      spec_q <= spec_d;
    end
  end : g_fifo

  // ---------------------------------------------------------------------------
  // Round-robin arbitration starting one past the last granted unit.
  // ---------------------------------------------------------------------------

  // Pick the first eligible unit in rotating priority order.
  always_comb begin : rr_pick
    grant_any = 1'b0;
    grant_idx = last_grant_q;
    for (int k = 1; k <= NUM_FU; k++) begin
      if (!grant_any && candidate[rr_index(last_grant_q, k)]) begin
        grant_any = 1'b1;
        grant_idx = rr_index(last_grant_q, k);
      end
    end
  end

  // Load the granted head into the output register; a resolve also clears
  // the spec bit of whatever the register holds.
  always_comb begin : out_next
    out_valid_d  = grant_any;
    out_rd_d     = out_rd_q;
    out_data_d   = out_data_q;
    out_tag_d    = out_tag_q;
    out_spec_d   = out_spec_q & ~resolve;
    last_grant_d = last_grant_q;
    if (grant_any) begin
      out_rd_d     = head_rd[grant_idx];
      out_data_d   = head_data[grant_idx];
      out_tag_d    = head_tag[grant_idx];
      out_spec_d   = head_spec[grant_idx] & ~resolve;
      last_grant_d = grant_idx;
    end
  end

  // Output register and arbitration pointer; FU0 has first priority after reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_valid_q  <= 1'b0;
      out_spec_q   <= 1'b0;
      out_rd_q     <= '0;
      out_data_q   <= '0;
      out_tag_q    <= '0;
      last_grant_q <= LAST_FU;
    end else begin
      out_valid_q  <= out_valid_d;
      out_spec_q   <= out_spec_d;
      out_rd_q     <= out_rd_d;
      out_data_q   <= out_data_d;
      out_tag_q    <= out_tag_d;
      last_grant_q <= last_grant_d;
    end
  end

  // A speculative result sitting in the output register is suppressed
  // combinationally during a flush so it never clears busy state.
  assign wb_write = out_valid_q & ~(flush & out_spec_q);
  assign wb_sel   = out_rd_q;
  assign wb_data  = out_data_q;
  assign wb_tag   = out_tag_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: a queue-based reference model predicts
// every writeback; expected writebacks go into a scoreboard that an
// independent monitor drains whenever the DUT strobes wb_write.
module tb_wb_arbiter;

  localparam int NUM_FU = 3;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 2;
  localparam int DEPTH  = 2;

  logic                     CLK = 1'b0;
  logic                     RST = 1'b1;
  logic [NUM_FU-1:0]        fu_valid = '0;
  logic [NUM_FU-1:0]        fu_ready;
  logic [NUM_FU*5-1:0]      fu_rd = '0;
  logic [NUM_FU*DATA_W-1:0] fu_data = '0;
  logic [NUM_FU*TAG_W-1:0]  fu_tag = '0;
  logic [NUM_FU-1:0]        fu_spec = '0;
  logic                     flush = 1'b0;
  logic                     resolve = 1'b0;
  logic                     wb_write;
  logic [4:0]               wb_sel;
  logic [DATA_W-1:0]        wb_data;
  logic [TAG_W-1:0]         wb_tag;

  wb_arbiter #(.NUM_FU(NUM_FU), .DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_rd(fu_rd), .fu_data(fu_data),
    .fu_tag(fu_tag), .fu_spec(fu_spec), .flush(flush), .resolve(resolve),
    .wb_write(wb_write), .wb_sel(wb_sel), .wb_data(wb_data), .wb_tag(wb_tag)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic              spec;
  } ent_t;

  typedef struct packed {
    int unsigned       cyc;
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } wb_t;

  // Reference model state.
  ent_t mq [NUM_FU][$];
  ent_t m_out;
  logic m_valid;
  int   m_last;

  wb_t  exp_q [$];
  wb_t  mon_e;
  int   checks = 0;
  int   failures = 0;
  int unsigned cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic model_reset();
    for (int i = 0; i < NUM_FU; i++) mq[i].delete();
    m_out   = '0;
    m_valid = 1'b0;
    m_last  = NUM_FU - 1;
  endtask

  // One bus cycle: drive inputs, check ready, predict this cycle's writeback,
  // then advance the model across the coming clock edge.
  task automatic drive_cycle(input logic [NUM_FU-1:0] v, input logic [NUM_FU*5-1:0] rd,
                             input logic [NUM_FU*DATA_W-1:0] d, input logic [NUM_FU*TAG_W-1:0] tg,
                             input logic [NUM_FU-1:0] sp, input logic fl, input logic rs);
    logic [NUM_FU-1:0] rdy;
    int   g;
    logic found;
    ent_t e;
    ent_t keep[$];
    @(negedge CLK);
    fu_valid = v; fu_rd = rd; fu_data = d; fu_tag = tg; fu_spec = sp;
    flush = fl; resolve = rs;
    #1;
    for (int i = 0; i < NUM_FU; i++) rdy[i] = (mq[i].size() < DEPTH);
    checks++;
    if (fu_ready !== rdy) begin
      failures++;
      $display("FAIL fu_ready cyc=%0d got=%b required=%b", cyc, fu_ready, rdy);
    end
    if (m_valid && !(fl && m_out.spec))
      exp_q.push_back('{cyc: cyc, rd: m_out.rd, data: m_out.data, tag: m_out.tag});
    // Round-robin choice among non-empty queues whose head survives the flush.
    found = 1'b0;
    g = 0;
    for (int k = 1; k <= NUM_FU; k++) begin
      int idx;
      idx = (m_last + k) % NUM_FU;
      if (!found && mq[idx].size() > 0 && !(fl && mq[idx][0].spec)) begin
        found = 1'b1;
        g = idx;
      end
    end
    if (found) begin
      m_out = mq[g].pop_front();
      m_out.spec = m_out.spec & ~rs;
      m_valid = 1'b1;
      m_last = g;
    end else begin
      m_valid = 1'b0;
      m_out.spec = m_out.spec & ~rs;
    end
    for (int i = 0; i < NUM_FU; i++) begin
      keep.delete();
      foreach (mq[i][j]) begin
        e = mq[i][j];
        if (!(fl && e.spec)) begin
          e.spec = e.spec & ~rs;
          keep.push_back(e);
        end
      end
      mq[i] = keep;
    end
    for (int i = 0; i < NUM_FU; i++) begin
      if (v[i] && rdy[i] && rd[i*5 +: 5] != 5'd0 && !(fl && sp[i])) begin
        e.rd = rd[i*5 +: 5];
        e.data = d[i*DATA_W +: DATA_W];
        e.tag = tg[i*TAG_W +: TAG_W];
        e.spec = sp[i] & ~rs;
        mq[i].push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle('0, '0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic rand_cycle(input int pv, input int pf, input int pr);
    logic [NUM_FU-1:0] v, sp;
    logic [NUM_FU*5-1:0] rd;
    logic [NUM_FU*DATA_W-1:0] d;
    logic [NUM_FU*TAG_W-1:0] tg;
    for (int i = 0; i < NUM_FU; i++) begin
      v[i] = ($urandom_range(0, 99) < pv);
      rd[i*5 +: 5] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      d[i*DATA_W +: DATA_W] = $urandom;
      tg[i*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, 3));
      sp[i] = ($urandom_range(0, 2) == 0);
    end
    drive_cycle(v, rd, d, tg, sp, $urandom_range(0, 99) < pf, $urandom_range(0, 99) < pr);
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if (fu_ready !== '1 || wb_write !== 1'b0 || wb_sel !== 5'd0 || wb_data !== '0 || wb_tag !== '0) begin
      failures++;
      $display("FAIL %s got ready=%b write=%b sel=%0d data=%h tag=%0d required ready=111 write=0 sel=0 data=0 tag=0",
               name, fu_ready, wb_write, wb_sel, wb_data, wb_tag);
    end
  endtask

  // Asynchronous reset between clock edges with traffic still queued.
  task automatic midstream_reset();
    @(negedge CLK);
    fu_valid = '0; flush = 1'b0; resolve = 1'b0;
    #1 RST = 1'b1;
    #1;
    checks++;
    if (wb_write !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_wb got=%b required=0", wb_write);
    end
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check_reset_vals("midstream_reset_vals");
  endtask

  // Monitor: every DUT writeback must match the oldest expected one.
  initial begin
    forever begin
      @(negedge CLK);
      #2;
      if (wb_write !== 1'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL wb_unexpected cyc=%0d got sel=%0d data=%h tag=%0d required no write",
                   cyc, wb_sel, wb_data, wb_tag);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.cyc != cyc || mon_e.rd !== wb_sel || mon_e.data !== wb_data || mon_e.tag !== wb_tag) begin
            failures++;
            $display("FAIL wb_compare got cyc=%0d sel=%0d data=%h tag=%0d required cyc=%0d sel=%0d data=%h tag=%0d",
                     cyc, wb_sel, wb_data, wb_tag, mon_e.cyc, mon_e.rd, mon_e.data, mon_e.tag);
          end else begin
            $display("wb ok cyc=%0d sel=%0d data=%h tag=%0d", cyc, wb_sel, wb_data, wb_tag);
          end
        end
      end
    end
  end

  initial begin
    model_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    #1;
    check_reset_vals("reset_vals");

    // Single result from FU1.
    drive_cycle(3'b010, {5'd0, 5'd7, 5'd0}, {32'd0, 32'hDEADBEEF, 32'd0},
                {2'd0, 2'd2, 2'd0}, 3'b000, 1'b0, 1'b0);
    idle(4);

    // All three units streaming: rotating writeback order.
    for (int n = 0; n < 12; n++)
      drive_cycle(3'b111, {5'd3, 5'd2, 5'd1}, {$urandom, $urandom, $urandom},
                  {2'd3, 2'd2, 2'd1}, 3'b000, 1'b0, 1'b0);
    idle(6);

    // Backpressure on FU0 while FU1/FU2 stream.
    for (int n = 0; n < 8; n++)
      drive_cycle({2'b11, n < 3}, {5'd12, 5'd11, 5'(13 + n)}, {$urandom, $urandom, $urandom},
                  {2'd1, 2'd1, 2'd1}, 3'b000, 1'b0, 1'b0);
    idle(6);

    // Flush: FU0 holds [rd4, rd5 spec], output holds rd9 spec.
    drive_cycle(3'b001, {5'd0, 5'd0, 5'd10}, {32'd0, 32'd0, 32'hA}, '0, 3'b000, 1'b0, 1'b0);
    drive_cycle(3'b011, {5'd0, 5'd9, 5'd4}, {32'd0, 32'h9, 32'h4}, '0, 3'b010, 1'b0, 1'b0);
    drive_cycle(3'b001, {5'd0, 5'd0, 5'd5}, {32'd0, 32'd0, 32'h5}, '0, 3'b001, 1'b0, 1'b0);
    drive_cycle('0, '0, '0, '0, '0, 1'b1, 1'b0);
    idle(4);

    // Flush and resolve together squash a queued spec result.
    drive_cycle(3'b100, {5'd6, 5'd0, 5'd0}, {32'h6, 32'd0, 32'd0}, '0, 3'b100, 1'b0, 1'b0);
    drive_cycle('0, '0, '0, '0, '0, 1'b1, 1'b1);
    idle(3);
    // Resolve alone protects it from a later flush.
    drive_cycle(3'b100, {5'd6, 5'd0, 5'd0}, {32'h66, 32'd0, 32'd0}, '0, 3'b100, 1'b0, 1'b0);
    drive_cycle('0, '0, '0, '0, '0, 1'b0, 1'b1);
    drive_cycle('0, '0, '0, '0, '0, 1'b1, 1'b0);
    idle(3);

    // x0 destination is never written back.
    drive_cycle(3'b001, {5'd0, 5'd0, 5'd0}, {32'd0, 32'd0, 32'h1234}, '0, 3'b000, 1'b0, 1'b0);
    idle(3);

    // Randomized traffic with periodic asynchronous resets mid-stream.
    for (int blk = 0; blk < 5; blk++) begin
      for (int n = 0; n < 500; n++) rand_cycle(70, 8, 10);
      for (int n = 0; n < 4; n++) rand_cycle(100, 0, 0);
      midstream_reset();
    end

    idle(12);
    @(negedge CLK);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d pending required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter between the functional units (scalar ALU, load/store, matrix unit) and the writeback port of the register status table and scalar register file. Each FU drives its results into a small per-FU FIFO. A round-robin arbiter picks one result per cycle and registers it as `wb_sel`/`wb_write`/`wb_data`. Speculative results are tracked so that a dispatch-side `flush` discards them before they can clear register busy state.

## Interface
Parameters:
- `NUM_FU`, 3, number of functional-unit result sources
- `DATA_W`, 32, result data width
- `TAG_W`, 2, dispatch tag width (matches the dispatch tag)
- `DEPTH`, 2, entries per FU FIFO (power of two, ≥2)

Ports:
- `CLK`  in  1  clock; one clock for the whole block
- `RST`  in  1  reset, asynchronous, active-high
- `fu_valid`  in  NUM_FU  result valid per FU
- `fu_ready`  out  NUM_FU  FIFO not full per FU
- `fu_rd`  in  NUM_FU*5  destination register per FU; FU i uses bits [5i+4:5i]
- `fu_data`  in  NUM_FU*DATA_W  result data per FU
- `fu_tag`  in  NUM_FU*TAG_W  dispatch tag carried with the result
- `fu_spec`  in  NUM_FU  result was issued under an unresolved branch
- `flush`  in  1  squash all speculative results
- `resolve`  in  1  branch resolved correct; clear all spec bits
- `wb_write`  out  1  writeback strobe to the status table and register file
- `wb_sel`  out  5  writeback register index
- `wb_data`  out  DATA_W  writeback data
- `wb_tag`  out  TAG_W  writeback tag

## Operation
- **Enqueue.** FU i's result is enqueued when `fu_valid[i] & fu_ready[i]`. `fu_ready[i] = (count_i != DEPTH)` uses the registered count only; there is no combinational path from dequeue to ready.
- **Enqueue-side drops.** A handshaken result with `fu_rd == 0` is accepted and discarded, because x0 never writes back. A handshaken result with `fu_spec = 1` in a `flush` cycle is also accepted and discarded.
- **FIFO entry.** Each entry holds {rd, data, tag, spec}. On enqueue, the spec bit is stored as `fu_spec & ~resolve`.
- **Arbitration.** Each cycle, candidates are the FIFOs that are non-empty and whose head is not being killed by `flush`. Round-robin grant: priority starts at `last_grant + 1` (mod NUM_FU). On a grant, `last_grant` updates to the granted FU. With no grant, it holds.
- **Output register.**
  - The granted head is dequeued and loaded into the output register {valid, rd, data, tag, spec} at the same edge.
  - With no grant, valid loads 0.
  - `wb_write = out_valid & ~(flush & out_spec)`.
  - `wb_sel`, `wb_data`, `wb_tag` are driven from the register; they are don't-care when `wb_write = 0`.
- **Flush.**
  - Every FIFO entry with spec = 1 is invalidated at the edge ending the flush cycle.
  - FIFOs are compacted so the surviving non-spec entries keep their order.
  - The output register's spec entry is suppressed combinationally (see `wb_write` above).
- **Resolve.**
  - All stored spec bits clear at the edge, including the output register's.
  - If `flush` and `resolve` are asserted together, `flush` wins. Spec entries are squashed, and incoming spec results are dropped.
- **Count arithmetic.** Per FIFO, `count_next = count + enq - deq - killed`. It never underflows or overflows. Enqueue and dequeue in the same cycle at full or at empty are both legal:
  - At full, enqueue uses the registered `fu_ready` (0), so no enqueue happens.
  - At empty, nothing can be dequeued. An incoming result is not bypassed into the output register.

## Timing
- **Reset values.** `fu_ready` = all 1, `wb_write` = 0, `wb_sel` = 0, `wb_data` = 0, `wb_tag` = 0. All counts = 0. `last_grant` = NUM_FU-1, so FU0 has first priority.
- **Latency.** A result handshaken at edge t appears on `wb_*` during cycle t+1 to t+2, i.e. at minimum 2 cycles after `fu_valid` rises. There is no bypass.
- **Throughput.** One writeback per cycle, sustained. Each FU is guaranteed a grant within NUM_FU cycles while it is non-empty.
- **Asynchronous reset mid-operation.** All FIFOs are emptied and `wb_write` drops immediately, without waiting for `CLK`.
- **Ready timing.** `fu_ready[i]` deasserts the cycle after the FIFO fills. It reasserts the cycle after a dequeue or flush frees an entry.

## Test plan
- **Single result.** After reset, FU1 presents rd=7, data=0xDEADBEEF, tag=2, spec=0 for one cycle → `wb_write` = 1 exactly 2 cycles later with `wb_sel` = 7, `wb_data` = 0xDEADBEEF, `wb_tag` = 2, for one cycle.
- **Round-robin fairness.** FU0/1/2 each hold `fu_valid` continuously with rd = 1/2/3 → `wb_sel` sequence 1,2,3,1,2,3… with no gaps. Every FU's `fu_ready` stays 1 or toggles, and no result is lost.
- **Backpressure.** FU0 is sent 3 results while FU1/FU2 stream continuously → `fu_ready[0]` drops after 2 accepted results. All 3 of FU0's results are written back in order.
- **Flush.** FU0 queue holds [rd=4 spec=0, rd=5 spec=1]. The output register holds rd=9 spec=1. Assert `flush` → `wb_write` = 0 that cycle. rd=5 is never written. rd=4 is written next. `fu_ready[0]` = 1.
- **Flush and resolve together.** Assert `flush` and `resolve` together with a spec entry rd=6 queued → rd=6 is dropped. Separately, `resolve` alone with rd=6 queued → a later `flush` does not drop rd=6, and it is written back.
- **x0 and reset.** A result with rd=0 → never `wb_write`. Asserting `RST` mid-stream with 2 entries queued → `wb_write` = 0 immediately, and no queued result appears after reset release.
